// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Next-PC select encoding plus default widths/step/reset constants.
package pc_pkg;

  localparam int PC_ADDR_W_DEF     = 16;
  localparam int PC_DISP_W_DEF     = 8;
  localparam int PC_INCR_DEF       = 1;
  localparam int PC_RESET_ADDR_DEF = 0;
  localparam int PC_RAS_DEPTH_DEF  = 4;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [2:0] {
    PC_SEL_RST,
    PC_SEL_HOLD,
    PC_SEL_JUMP,
    PC_SEL_RET,
    PC_SEL_BRANCH,
    PC_SEL_INCR
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of DEPTH entries addressed by a top
// pointer, with a saturating occupancy count. A push into a full stack lands
// on the oldest slot, so the newest DEPTH return addresses are always kept.
// A pop on an empty stack is ignored here; the caller flags it.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = PC_RAS_DEPTH_DEF,
  parameter int W     = PC_ADDR_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

  // Storage: a push always writes the slot just above the current top
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[ptr_q + PTR_W'(1)] <= wdata_i;
    end
  end

  // Top pointer wraps freely (power-of-2 depth); count saturates at DEPTH
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full_o) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential step, PC-relative branch, absolute
// jump, stall hold and (optionally) call/return through a return-address stack.
// Build option: define PC_RAS_EN to include the return-address stack; without
// it call_i/ret_i are ignored and ras_err_o is constant 0.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = PC_ADDR_W_DEF,
  parameter int                DISP_W     = PC_DISP_W_DEF,
  parameter int                INCR       = PC_INCR_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_ADDR_DEF),
  parameter int                RAS_DEPTH  = PC_RAS_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_tgt_i,
  input  logic              branch_i,
  input  logic [DISP_W-1:0] displacement_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] addr_imem_o,
  output logic              addr_valid_o,
  output logic              ras_err_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] incr_pc, branch_pc, disp_ext;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop, ras_empty, ras_full;
  pc_sel_e           sel;

  // Both adders work from the current PC; overflow wraps silently
  assign disp_ext  = {{(ADDR_W - DISP_W){displacement_i[DISP_W-1]}}, displacement_i};
  assign incr_pc   = pc_q + ADDR_W'(INCR);
  assign branch_pc = pc_q + disp_ext;

`ifdef PC_RAS_EN
  // call only rides on a real jump, ret only when no jump; neither while stalled
  assign ras_push = !stall_i && jump_i && call_i;
  assign ras_pop  = !stall_i && !jump_i && ret_i;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .wdata_i (incr_pc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );
`else
  // No stack: ret never selects, call is a plain jump, error can never set
  assign ras_push  = 1'b0;
  assign ras_pop   = 1'b0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  logic unused_ras_ports;
  assign unused_ras_ports = &{1'b0, call_i, ret_i};
`endif

  // Priority decode of the next-PC source
  always_comb begin
    sel = PC_SEL_INCR;
    if (rst_i)         sel = PC_SEL_RST;
    else if (stall_i)  sel = PC_SEL_HOLD;
    else if (jump_i)   sel = PC_SEL_JUMP;
    else if (ras_pop)  sel = PC_SEL_RET;
    else if (branch_i) sel = PC_SEL_BRANCH;
  end

  // Next-PC mux; a return from an empty stack falls back to the sequential step
  always_comb begin
    pc_d = incr_pc;
    case (sel)
      PC_SEL_RST:    pc_d = RESET_ADDR;
      PC_SEL_HOLD:   pc_d = pc_q;
      PC_SEL_JUMP:   pc_d = jump_tgt_i;
      PC_SEL_RET:    pc_d = ras_empty ? incr_pc : ras_top;
      PC_SEL_BRANCH: pc_d = branch_pc;
      default:       pc_d = incr_pc;
    endcase
  end

  // Sticky stack error: overflowing push or underflowing pop
  always_comb begin
    err_d = err_q | (ras_push & ras_full) | (ras_pop & ras_empty);
  end

  // PC, fetch-valid and error registers; reset overrides every other input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign addr_imem_o  = pc_q;
  assign addr_valid_o = valid_q;
  assign ras_err_o    = err_q;

endmodule
